// File: rtl/misc_v_pkg.sv
`default_nettype none
// ============================================================================
// Package : misc_v_pkg
// Brief   : Shared widths and ALU opcode encodings for the operand stage.
// Rev     : 1.0  initial release
// ============================================================================
package misc_v_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;
   localparam int IMM_W      = 6;

   localparam logic [2:0] OP_NOOP    = 3'd0;
   localparam logic [2:0] OP_ADD     = 3'd1;
   localparam logic [2:0] OP_SUB     = 3'd2;
   localparam logic [2:0] OP_OR      = 3'd3;
   localparam logic [2:0] OP_AND     = 3'd4;
   localparam logic [2:0] OP_ILLEGAL = 3'd5;
   localparam logic [2:0] OP_SHL     = 3'd6;
   localparam logic [2:0] OP_SHR     = 3'd7;

   // Only real ALU operations with a non-zero destination update the register file.
   function automatic logic op_writes(input logic [2:0] op, input logic rd_nonzero);
      return (op != OP_NOOP) && (op != OP_ILLEGAL) && rd_nonzero;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_hazard_unit
// Brief  : Compares incoming sources against the two in-flight destinations
//          and produces the stall request and per-operand forward selects.
// Config : ALU_OPERAND_FWD_EN enables forwarding of S2 hits from ALU_RESULT.
// Rev    : 1.0  initial release
// ============================================================================
module alu_hazard_unit #(
   parameter int REG_ADDR_W = misc_v_pkg::REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] i_rs1_id,
   input  logic [REG_ADDR_W-1:0] i_rs2_id,
   input  logic                  i_use_imm,
   input  logic [REG_ADDR_W-1:0] i_s1_rd,
   input  logic                  i_s1_writes,
   input  logic [REG_ADDR_W-1:0] i_s2_rd,
   input  logic                  i_s2_writes,
   output logic                  o_hazard,
   output logic                  o_fwd_rs1,
   output logic                  o_fwd_rs2
);

   logic w_s1_live;
   logic w_s2_live;
   logic w_s1_rs1;
   logic w_s1_rs2;
   logic w_s2_rs1;
   logic w_s2_rs2;

   // Register 0 is hardwired zero, so a slot targeting it never holds a pending value.
   assign w_s1_live = i_s1_writes && (i_s1_rd != '0);
   assign w_s2_live = i_s2_writes && (i_s2_rd != '0);

   assign w_s1_rs1 = w_s1_live && (i_s1_rd == i_rs1_id);
   assign w_s1_rs2 = w_s1_live && !i_use_imm && (i_s1_rd == i_rs2_id);
   assign w_s2_rs1 = w_s2_live && (i_s2_rd == i_rs1_id);
   assign w_s2_rs2 = w_s2_live && !i_use_imm && (i_s2_rd == i_rs2_id);

`ifdef ALU_OPERAND_FWD_EN
   assign o_hazard  = w_s1_rs1 || w_s1_rs2;
   assign o_fwd_rs1 = w_s2_rs1;
   assign o_fwd_rs2 = w_s2_rs2;
`else
   // Without forwarding the op waits until the register file holds the result.
   assign o_hazard  = w_s1_rs1 || w_s1_rs2 || w_s2_rs1 || w_s2_rs2;
   assign o_fwd_rs1 = 1'b0;
   assign o_fwd_rs2 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : alu_operand_stage
// Brief  : Operand capture and issue stage ahead of the registered 16-bit ALU,
//          with RAW hazard bubbles and optional result forwarding.
// Config : define ALU_OPERAND_FWD_EN to forward ALU_RESULT on S2 hits.
// Rev    : 1.0  initial release
// ============================================================================
module alu_operand_stage #(
   parameter int DATA_W     = misc_v_pkg::DATA_W,
   parameter int REG_ADDR_W = misc_v_pkg::REG_ADDR_W,
   parameter int IMM_W      = misc_v_pkg::IMM_W
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [2:0]            IN_OP,
   input  logic [REG_ADDR_W-1:0] IN_RS1_ID,
   input  logic [REG_ADDR_W-1:0] IN_RS2_ID,
   input  logic [REG_ADDR_W-1:0] IN_RD_ID,
   input  logic [DATA_W-1:0]     IN_RS1_DATA,
   input  logic [DATA_W-1:0]     IN_RS2_DATA,
   input  logic [IMM_W-1:0]      IN_IMM,
   input  logic                  IN_USE_IMM,
   input  logic [DATA_W-1:0]     ALU_RESULT,
   output logic [DATA_W-1:0]     FIRST_OPERAND,
   output logic [DATA_W-1:0]     SECOND_OPERAND,
   output logic [2:0]            ALU_OP,
   output logic [REG_ADDR_W-1:0] OUT_RD_ID,
   output logic                  OUT_WRITES,
   output logic                  ILLEGAL_OP,
   output logic [15:0]           BUBBLE_COUNT
);
   import misc_v_pkg::*;

   logic [DATA_W-1:0]     r_first;
   logic [DATA_W-1:0]     r_second;
   logic [2:0]            r_alu_op;
   logic [REG_ADDR_W-1:0] r_s1_rd;
   logic                  r_s1_writes;
   logic [REG_ADDR_W-1:0] r_s2_rd;
   logic                  r_s2_writes;
   logic                  r_illegal;
   logic [15:0]           r_bubble_count;

   logic                  w_hazard;
   logic                  w_fwd_rs1;
   logic                  w_fwd_rs2;
   logic                  w_take;
   logic                  w_illegal;
   logic [2:0]            w_alu_op;
   logic                  w_writes;
   logic [DATA_W-1:0]     w_imm_ext;
   logic [DATA_W-1:0]     w_first;
   logic [DATA_W-1:0]     w_second;

   alu_hazard_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .i_rs1_id    (IN_RS1_ID),
      .i_rs2_id    (IN_RS2_ID),
      .i_use_imm   (IN_USE_IMM),
      .i_s1_rd     (r_s1_rd),
      .i_s1_writes (r_s1_writes),
      .i_s2_rd     (r_s2_rd),
      .i_s2_writes (r_s2_writes),
      .o_hazard    (w_hazard),
      .o_fwd_rs1   (w_fwd_rs1),
      .o_fwd_rs2   (w_fwd_rs2)
   );

   assign IN_READY  = !RST && !w_hazard;
   assign w_take    = IN_VALID && IN_READY;

   // Illegal opcodes still flow through, but as a non-writing noop.
   assign w_illegal = (IN_OP == OP_ILLEGAL);
   assign w_alu_op  = w_illegal ? OP_NOOP : IN_OP;
   assign w_writes  = op_writes(IN_OP, IN_RD_ID != '0);

   assign w_imm_ext = {{(DATA_W-IMM_W){IN_IMM[IMM_W-1]}}, IN_IMM};
   assign w_first   = w_fwd_rs1 ? ALU_RESULT : IN_RS1_DATA;
   assign w_second  = IN_USE_IMM ? w_imm_ext
                    : (w_fwd_rs2 ? ALU_RESULT : IN_RS2_DATA);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_first        <= '0;
         r_second       <= '0;
         r_alu_op       <= OP_NOOP;
         r_s1_rd        <= '0;
         r_s1_writes    <= 1'b0;
         r_s2_rd        <= '0;
         r_s2_writes    <= 1'b0;
         r_illegal      <= 1'b0;
         r_bubble_count <= '0;
      end else begin
         r_s2_rd     <= r_s1_rd;
         r_s2_writes <= r_s1_writes;
         if (w_take) begin
            r_first     <= w_first;
            r_second    <= w_second;
            r_alu_op    <= w_alu_op;
            r_s1_rd     <= IN_RD_ID;
            r_s1_writes <= w_writes;
            r_illegal   <= w_illegal;
         end else begin
            r_first     <= '0;
            r_second    <= '0;
            r_alu_op    <= OP_NOOP;
            r_s1_rd     <= '0;
            r_s1_writes <= 1'b0;
            r_illegal   <= 1'b0;
         end
         // Only stalls of a real offered op count as inserted bubbles.
         if (IN_VALID && w_hazard && (r_bubble_count != 16'hFFFF)) begin
            r_bubble_count <= r_bubble_count + 16'd1;
         end
      end
   end

   assign FIRST_OPERAND  = r_first;
   assign SECOND_OPERAND = r_second;
   assign ALU_OP         = r_alu_op;
   assign OUT_RD_ID      = r_s1_rd;
   assign OUT_WRITES     = r_s1_writes;
   assign ILLEGAL_OP     = r_illegal;
   assign BUBBLE_COUNT   = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_operand_stage
// Brief  : Random and directed bench; expected operands come from an
//          in-order architectural register model, the ALU/RF are emulated.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

   typedef struct {
      logic [2:0] op;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [2:0] rd;
      logic [5:0] imm;
      logic       use_imm;
   } op_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IN_VALID;
   logic        IN_READY;
   logic [2:0]  IN_OP;
   logic [2:0]  IN_RS1_ID;
   logic [2:0]  IN_RS2_ID;
   logic [2:0]  IN_RD_ID;
   logic [15:0] IN_RS1_DATA;
   logic [15:0] IN_RS2_DATA;
   logic [5:0]  IN_IMM;
   logic        IN_USE_IMM;
   logic [15:0] ALU_RESULT;
   logic [15:0] FIRST_OPERAND;
   logic [15:0] SECOND_OPERAND;
   logic [2:0]  ALU_OP;
   logic [2:0]  OUT_RD_ID;
   logic        OUT_WRITES;
   logic        ILLEGAL_OP;
   logic [15:0] BUBBLE_COUNT;

   logic [15:0] rf   [8];
   logic [15:0] arch [8];
   logic        prev_wr;
   logic [2:0]  prev_rd;

   logic [15:0] exp_first, exp_second;
   logic [2:0]  exp_op, exp_rd;
   logic        exp_wr, exp_ill;
   int          exp_cnt;
   logic [2:0]  h1_rd, h2_rd;
   logic        h1_wr, h2_wr;

   op_t  q[$];
   op_t  cur;
   bit   have_op;
   bit   rand_gaps;
   int   checks;
   int   failures;
   int   ill_seen;

`ifdef ALU_OPERAND_FWD_EN
   localparam int B2B_BUBBLES = 1;
`else
   localparam int B2B_BUBBLES = 2;
`endif

   assign IN_RS1_DATA = rf[IN_RS1_ID];
   assign IN_RS2_DATA = rf[IN_RS2_ID];

   alu_operand_stage dut (
      .CLK            (CLK),
      .RST            (RST),
      .IN_VALID       (IN_VALID),
      .IN_READY       (IN_READY),
      .IN_OP          (IN_OP),
      .IN_RS1_ID      (IN_RS1_ID),
      .IN_RS2_ID      (IN_RS2_ID),
      .IN_RD_ID       (IN_RD_ID),
      .IN_RS1_DATA    (IN_RS1_DATA),
      .IN_RS2_DATA    (IN_RS2_DATA),
      .IN_IMM         (IN_IMM),
      .IN_USE_IMM     (IN_USE_IMM),
      .ALU_RESULT     (ALU_RESULT),
      .FIRST_OPERAND  (FIRST_OPERAND),
      .SECOND_OPERAND (SECOND_OPERAND),
      .ALU_OP         (ALU_OP),
      .OUT_RD_ID      (OUT_RD_ID),
      .OUT_WRITES     (OUT_WRITES),
      .ILLEGAL_OP     (ILLEGAL_OP),
      .BUBBLE_COUNT   (BUBBLE_COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      case (op)
         3'd1:    return a + b;
         3'd2:    return a - b;
         3'd3:    return a | b;
         3'd4:    return a & b;
         3'd6:    return a << b[3:0];
         3'd7:    return a >> b[3:0];
         default: return 16'd0;
      endcase
   endfunction

   function automatic logic [15:0] sext(input logic [5:0] imm);
      return 16'($signed(imm));
   endfunction

   function automatic logic hit(input logic [2:0] src, input logic [2:0] rd, input logic wr);
      return wr && (rd != 3'd0) && (src == rd);
   endfunction

   function automatic op_t mk(input int op, input int rs1, input int rs2, input int rd,
                              input int imm, input int use_imm);
      op_t o;
      o.op      = 3'(op);
      o.rs1     = 3'(rs1);
      o.rs2     = 3'(rs2);
      o.rd      = 3'(rd);
      o.imm     = 6'(imm);
      o.use_imm = (use_imm != 0);
      return o;
   endfunction

   // One clock cycle: drive, check at negedge, update model and ALU/RF emulation.
   task automatic step();
      logic        s1h, s2h, rdy, tk, wr;
      logic [15:0] a, b, n_alu, n_wdat;
      logic        n_wen, n_pwr;
      logic [2:0]  n_wrd, n_prd;
      if (!have_op && (q.size() > 0) && (!rand_gaps || ($urandom_range(0, 3) != 0))) begin
         cur     = q.pop_front();
         have_op = 1'b1;
      end
      if (have_op) begin
         IN_VALID   = 1'b1;
         IN_OP      = cur.op;
         IN_RS1_ID  = cur.rs1;
         IN_RS2_ID  = cur.rs2;
         IN_RD_ID   = cur.rd;
         IN_IMM     = cur.imm;
         IN_USE_IMM = cur.use_imm;
      end else begin
         IN_VALID   = 1'b0;
         IN_OP      = 3'($urandom_range(0, 7));
         IN_RS1_ID  = 3'($urandom_range(0, 3));
         IN_RS2_ID  = 3'($urandom_range(0, 3));
         IN_RD_ID   = 3'($urandom_range(0, 3));
         IN_IMM     = 6'($urandom);
         IN_USE_IMM = 1'($urandom);
      end

      @(negedge CLK);
      chk("first_operand",  32'(FIRST_OPERAND),  32'(exp_first));
      chk("second_operand", 32'(SECOND_OPERAND), 32'(exp_second));
      chk("alu_op",         32'(ALU_OP),         32'(exp_op));
      chk("out_rd_id",      32'(OUT_RD_ID),      32'(exp_rd));
      chk("out_writes",     32'(OUT_WRITES),     32'(exp_wr));
      chk("illegal_op",     32'(ILLEGAL_OP),     32'(exp_ill));
      chk("bubble_count",   32'(BUBBLE_COUNT),   32'(exp_cnt));
      if (ILLEGAL_OP === 1'b1) ill_seen++;

      n_alu  = alu_f(ALU_OP, FIRST_OPERAND, SECOND_OPERAND);
      n_wen  = prev_wr;
      n_wrd  = prev_rd;
      n_wdat = ALU_RESULT;
      n_pwr  = OUT_WRITES;
      n_prd  = OUT_RD_ID;

      s1h = hit(IN_RS1_ID, h1_rd, h1_wr) || (!IN_USE_IMM && hit(IN_RS2_ID, h1_rd, h1_wr));
      s2h = hit(IN_RS1_ID, h2_rd, h2_wr) || (!IN_USE_IMM && hit(IN_RS2_ID, h2_rd, h2_wr));
`ifdef ALU_OPERAND_FWD_EN
      rdy = !RST && !s1h;
`else
      rdy = !RST && !s1h && !s2h;
`endif
      chk("in_ready", 32'(IN_READY), 32'(rdy));
      tk = IN_VALID && rdy;

      if (RST) exp_cnt = 0;
      else if (IN_VALID && !rdy && (exp_cnt < 65535)) exp_cnt++;

      h2_rd = RST ? 3'd0 : h1_rd;
      h2_wr = RST ? 1'b0 : h1_wr;
      if (tk) begin
         a  = (cur.rs1 == 3'd0) ? 16'd0 : arch[cur.rs1];
         b  = cur.use_imm ? sext(cur.imm) : ((cur.rs2 == 3'd0) ? 16'd0 : arch[cur.rs2]);
         wr = (cur.op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7}) && (cur.rd != 3'd0);
         exp_first  = a;
         exp_second = b;
         exp_op     = (cur.op == 3'd5) ? 3'd0 : cur.op;
         exp_rd     = cur.rd;
         exp_wr     = wr;
         exp_ill    = (cur.op == 3'd5);
         if (wr) arch[cur.rd] = alu_f(cur.op, a, b);
         have_op = 1'b0;
      end else begin
         exp_first  = 16'd0;
         exp_second = 16'd0;
         exp_op     = 3'd0;
         exp_rd     = 3'd0;
         exp_wr     = 1'b0;
         exp_ill    = 1'b0;
      end
      h1_rd = exp_rd;
      h1_wr = exp_wr;

      @(posedge CLK);
      #1;
      ALU_RESULT = n_alu;
      if (n_wen && (n_wrd != 3'd0)) rf[n_wrd] = n_wdat;
      prev_wr = n_pwr;
      prev_rd = n_prd;
   endtask

   task automatic drain(input string tag, input int max_steps);
      int n;
      n = 0;
      while ((have_op || (q.size() > 0)) && (n < max_steps)) begin
         step();
         n++;
      end
      chk({tag, "_drain_left"}, 32'(q.size()) + 32'(have_op), 32'd0);
      repeat (3) step();
   endtask

   task automatic set_reg(input int r, input logic [15:0] v);
      rf[r]   = v;
      arch[r] = v;
   endtask

   initial begin
      int base;
      int ill0;
      checks    = 0;
      failures  = 0;
      ill_seen  = 0;
      have_op   = 1'b0;
      rand_gaps = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rf[i]   = (i == 0) ? 16'd0 : 16'($urandom);
         arch[i] = rf[i];
      end
      IN_VALID = 1'b0; IN_OP = 3'd0; IN_RS1_ID = 3'd0; IN_RS2_ID = 3'd0; IN_RD_ID = 3'd0;
      IN_IMM = 6'd0; IN_USE_IMM = 1'b0; ALU_RESULT = 16'd0;
      prev_wr = 1'b0; prev_rd = 3'd0;
      exp_first = 16'd0; exp_second = 16'd0; exp_op = 3'd0; exp_rd = 3'd0;
      exp_wr = 1'b0; exp_ill = 1'b0; exp_cnt = 0;
      h1_rd = 3'd0; h1_wr = 1'b0; h2_rd = 3'd0; h2_wr = 1'b0;

      // Reset: outputs zero, IN_READY low, then high once released.
      RST = 1'b1;
      @(posedge CLK);
      #1;
      step();
      step();
      RST = 1'b0;
      step();

      // Independent add.
      set_reg(1, 16'd15);
      set_reg(2, 16'd28);
      base = exp_cnt;
      q.push_back(mk(1, 1, 2, 3, 0, 0));
      drain("t_add", 20);
      chk("t_add_bubbles", 32'(BUBBLE_COUNT), 32'(base));

      // Immediate operand; rs2 matching the in-flight rd must not stall.
      set_reg(4, 16'hFFF3);
      base = exp_cnt;
      q.push_back(mk(1, 1, 2, 3, 0, 0));
      q.push_back(mk(2, 4, 3, 5, 6'b111101, 1));
      drain("t_imm", 20);
      chk("t_imm_bubbles", 32'(BUBBLE_COUNT), 32'(base));

      // Back-to-back RAW dependency.
      base = exp_cnt;
      q.push_back(mk(1, 1, 2, 3, 0, 0));
      q.push_back(mk(2, 3, 2, 6, 0, 0));
      drain("t_b2b", 20);
      chk("t_b2b_bubbles", 32'(BUBBLE_COUNT), 32'(base + B2B_BUBBLES));

      // rd=0 producer, r0 reader, illegal op and its nominal destination reader.
      base = exp_cnt;
      ill0 = ill_seen;
      q.push_back(mk(1, 1, 2, 0, 0, 0));
      q.push_back(mk(3, 0, 0, 2, 0, 0));
      q.push_back(mk(5, 1, 1, 1, 0, 0));
      q.push_back(mk(1, 1, 1, 4, 0, 0));
      drain("t_r0_ill", 20);
      chk("t_r0_ill_bubbles", 32'(BUBBLE_COUNT), 32'(base));
      chk("t_illegal_pulses", 32'(ill_seen), 32'(ill0 + 1));

      // Reset asserted while a dependent op is stalled.
      q.push_back(mk(1, 1, 1, 3, 0, 0));
      q.push_back(mk(2, 3, 1, 6, 0, 0));
      step();
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("t_rst_count_cleared", 32'(BUBBLE_COUNT), 32'd0);
      drain("t_rst_reissue", 20);
      chk("t_rst_reissue_bubbles", 32'(BUBBLE_COUNT), 32'd0);

      // Randomized traffic over a small register set to provoke hazards.
      rand_gaps = 1'b1;
      for (int i = 0; i < 300; i++) begin
         q.push_back(mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 1)));
      end
      drain("t_random", 4000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue/operand stage directly upstream of the 16-bit ALU. It registers the ALU inputs FirstInput, SecondInput and ALUOp.
- Selects register or sign-extended immediate operands, tracks destination registers of the two ops ahead of it, and inserts noop bubbles on read-after-write hazards.
- Forwards the ALU result back into operand capture.
- Upstream decode hands ops over with a valid/ready handshake.

Parameters:
- DATA_W, 16, operand/result width
- REG_ADDR_W, 3, register id width; id 0 is hardwired zero
- IMM_W, 6, immediate width, sign-extended to DATA_W

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  upstream op valid
- IN_READY  out  1  stage accepts op this cycle (transfer = IN_VALID & IN_READY)
- IN_OP  in  3  ALU opcode: 0 noop, 1 add, 2 sub, 3 or, 4 and, 6 shl, 7 shr; 5 illegal
- IN_RS1_ID, IN_RS2_ID, IN_RD_ID  in  REG_ADDR_W  source/destination register ids
- IN_RS1_DATA, IN_RS2_DATA  in  DATA_W  register file read data
- IN_IMM  in  IMM_W  immediate
- IN_USE_IMM  in  1  second operand = sign-extended IN_IMM; rs2 ignored for hazards
- ALU_RESULT  in  DATA_W  ALU OutputData
- FIRST_OPERAND, SECOND_OPERAND  out  DATA_W  to ALU FirstInput/SecondInput
- ALU_OP  out  3  to ALU ALUOp
- OUT_RD_ID  out  REG_ADDR_W  destination of presented op
- OUT_WRITES  out  1  presented op writes a register
- ILLEGAL_OP  out  1  one-cycle pulse, registered with the op
- BUBBLE_COUNT  out  16  bubbles inserted since reset, saturating at 0xFFFF

Behaviour:
- Reset: all outputs 0 (ALU_OP=0 noop, OUT_WRITES=0, ILLEGAL_OP=0, BUBBLE_COUNT=0); tracking slots S1 and S2 cleared.
- IN_READY is 0 during the RST cycle and 1 afterwards unless a hazard exists.
- Timing: the ALU is registered.
  - Op presented on the outputs in cycle C is held in S1; its result appears on ALU_RESULT in cycle C+1, tracked as S2.
  - The register file writes ALU_RESULT at the end of C+1 and is not write-through.
- Every cycle, S2 <= S1 (rd, writes). S1 <= the accepted op, or a bubble (rd=0, writes=0).
- Outputs update one cycle after acceptance (latency 1). A cycle with no transfer drives a bubble: ALU_OP=0, operands 0.
- Hazard: a source used by the incoming op (rs1 always; rs2 only when !IN_USE_IMM) equals a slot rd, with that slot's writes=1 and rd!=0.
- Hazard handling:
  - Hazard on S1: IN_READY=0, bubble issued, BUBBLE_COUNT+1 (only when IN_VALID=1).
  - Hazard on S2 only: forwarding applies (see Optional Feature).
- OUT_WRITES=1 iff op in {1,2,3,4,6,7} and rd!=0.
- Opcode 5: accepted, presented as ALU_OP=0, writes=0, ILLEGAL_OP=1 for that cycle; never a hazard source.
- Immediate: SECOND_OPERAND = {{(DATA_W-IMM_W){IN_IMM[IMM_W-1]}}, IN_IMM}.
- Shift ops pass the second operand unchanged; the ALU interprets negative amounts.
- rs1 and rs2 may both hit; each operand's forward/stall is resolved independently. Any S1 hit stalls.
- RST mid-bubble: clears slots and the counter; the pending op is re-offered by upstream.

Optional Feature:
- Macro ALU_OPERAND_FWD_EN.
- Defined:
  - An S2 hit captures ALU_RESULT instead of the RF data for that operand.
  - A dependent back-to-back op costs 1 bubble.
- Undefined:
  - S2 hits are also hazards (stall).
  - A back-to-back dependency costs 2 bubbles; the operand is taken from IN_RSx_DATA after the RF write.

Decomposition:
- Shared package misc_v_pkg: opcode localparams (OP_NOOP..OP_SHR, OP_ILLEGAL=5), DATA_W, REG_ADDR_W, IMM_W.
- One sub-module alu_hazard_unit: slot compare, stall and forward selects. The datapath registers stay in alu_operand_stage.

Test Plan:
- Reset → all outputs 0, BUBBLE_COUNT=0. Deassert RST → IN_READY=1 next cycle.
- Independent add: rs1 data 15, rs2 data 28, rd=3, op=1 → next cycle FIRST=15, SECOND=28, ALU_OP=1, OUT_WRITES=1, no bubble.
- IN_IMM=6'b111101, IN_USE_IMM=1, op=2, rs1 data -13 → SECOND=16'hFFFD, FIRST=16'hFFF3; rs2 id matching S1 rd causes no stall.
- Back-to-back RAW (needs fwd): add rd=3 (15+28), then sub rs1=3 held valid:
  - With ALU_OPERAND_FWD_EN: one bubble (IN_READY=0 one cycle), then FIRST=43, BUBBLE_COUNT=1.
  - Without: two bubbles, then FIRST=IN_RS1_DATA, BUBBLE_COUNT=2.
- rd=0 producer followed by a reader of r0, and op=5 → no bubble. The op=5 cycle shows ALU_OP=0, OUT_WRITES=0, ILLEGAL_OP=1 for one cycle.
- Assert RST during a bubble → next cycle all outputs 0, slots clear, the re-offered op issues without a bubble.
